cacheline_burst_adaptor: RTL and testbench

Memory-side responder for the 256-bit cacheline request/response protocol driven by the arbiter (read/write/address/wdata in, rdata/resp out). It accepts one line request at a time and converts it into a 4-beat, 64-bit burst transaction on the physical burst-memory port. On reads it reassembles the beats into a line; on writes it serialises the line. It sits between the arbiter's memory-side output and the burst memory model/controller.

---
 rtl/arbiter_ctrl_pkg.sv | 44 ++++
 rtl/cacheline_burst_adaptor_line_beat_buffer.sv | 41 ++++
 rtl/cacheline_burst_adaptor.sv | 155 +++++++++++++++
 tb/tb_cacheline_burst_adaptor.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/arbiter_ctrl_pkg.sv
// Shared arbiter/memory-side definitions: line-side bundles, burst-side bundles,
// and the cacheline burst adaptor state encoding.
package arbiter_ctrl;

  localparam int ADDR_W     = 32;
  localparam int LINE_W     = 256;
  localparam int BEAT_W     = 64;
  localparam int BEATS      = LINE_W / BEAT_W;
  localparam int BEAT_IDX_W = $clog2(BEATS);
  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(BEATS - 1);

  // Line-side bundles between the arbiter and its memory responder.
  typedef struct packed {
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } mem_out_sig_to_arb;

  typedef struct packed {
    logic [LINE_W-1:0] rdata;
    logic              resp;
  } mem_in_sig_to_arb;

  typedef enum logic [1:0] {
    ADP_IDLE,
    ADP_RD,
    ADP_WR,
    ADP_DONE
  } adaptor_state_e;

  typedef struct packed {
    logic [BEAT_W-1:0] rdata;
    logic              resp;
  } burst_in_t;

  typedef struct packed {
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [BEAT_W-1:0] wdata;
  } burst_out_t;

endpackage

// File: rtl/cacheline_burst_adaptor_line_beat_buffer.sv
// Line-wide register addressed in beats: whole-line load, single-beat write,
// single-beat read. Load takes priority over a beat write.
module line_beat_buffer
  import arbiter_ctrl::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic [LINE_W-1:0]     load_line,
  input  logic                  wr_en,
  input  logic [BEAT_IDX_W-1:0] wr_idx,
  input  logic [BEAT_W-1:0]     wr_beat,
  input  logic [BEAT_IDX_W-1:0] rd_idx,
  output logic [BEAT_W-1:0]     rd_beat,
  output logic [LINE_W-1:0]     line
);

  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] line_d;

  always_comb begin
    line_d = line_q;
    if (load_en) begin
      line_d = load_line;
    end else if (wr_en) begin
      line_d[wr_idx*BEAT_W +: BEAT_W] = wr_beat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign rd_beat = line_q[rd_idx*BEAT_W +: BEAT_W];
  assign line    = line_q;

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Converts one 256-bit line request into a 4-beat 64-bit burst and back.
// Optional watchdog abort is enabled with ADAPTOR_TIMEOUT_EN.
module cacheline_burst_adaptor
  import arbiter_ctrl::*;
#(
  parameter int TIMEOUT_CYCLES = 255
)
(
  input  logic          clk,
  input  logic          rst,
  input  logic          line_read,
  input  logic          line_write,
  input  logic [31:0]   line_addr,
  input  logic [255:0]  line_wdata,
  output logic [255:0]  line_rdata,
  output logic          line_resp,
  output logic          line_err,
  output logic          burst_read,
  output logic          burst_write,
  output logic [31:0]   burst_addr,
  output logic [63:0]   burst_wdata,
  input  logic [63:0]   burst_rdata,
  input  logic          burst_resp
);

  adaptor_state_e        state_q, state_d;
  logic [BEAT_IDX_W-1:0] k_q, k_d;
  burst_out_t            burst_q, burst_d;
  logic                  line_resp_q, line_resp_d;
  logic                  rd_beat_we;
  logic                  wr_line_load;
  burst_in_t             burst_in;
`ifdef ADAPTOR_TIMEOUT_EN
  logic [7:0]            idle_cnt_q, idle_cnt_d;
  logic                  line_err_q, line_err_d;
`endif

  assign burst_in = '{rdata: burst_rdata, resp: burst_resp};

  // Instance 0 assembles read beats into line_rdata; instance 1 holds the write line.
  logic [LINE_W-1:0] buf_line [2];
  logic [BEAT_W-1:0] buf_beat [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_buf
      line_beat_buffer u_buf (
        .clk       (clk),
        .rst       (rst),
        .load_en   ((gi == 1) ? wr_line_load : 1'b0),
        .load_line ((gi == 1) ? line_wdata : '0),
        .wr_en     ((gi == 0) ? rd_beat_we : 1'b0),
        .wr_idx    (k_q),
        .wr_beat   (burst_in.rdata),
        .rd_idx    (k_q + 2'd1),
        .rd_beat   (buf_beat[gi]),
        .line      (buf_line[gi])
      );
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    burst_d      = burst_q;
    line_resp_d  = 1'b0;
    rd_beat_we   = 1'b0;
    wr_line_load = 1'b0;
`ifdef ADAPTOR_TIMEOUT_EN
    idle_cnt_d   = '0;
    line_err_d   = 1'b0;
`endif
    unique case (state_q)
      ADP_IDLE: begin
        k_d = '0;
        if (line_read) begin
          state_d       = ADP_RD;
          burst_d.read  = 1'b1;
          burst_d.addr  = line_addr & ~32'h1F;
        end else if (line_write) begin
          state_d       = ADP_WR;
          burst_d.write = 1'b1;
          burst_d.addr  = line_addr & ~32'h1F;
          // Beat 0 must be on the bus in the first cycle burst_write is high.
          burst_d.wdata = line_wdata[BEAT_W-1:0];
          wr_line_load  = 1'b1;
        end
      end
      ADP_RD, ADP_WR: begin
        if (burst_in.resp) begin
          k_d = k_q + 2'd1;
          if (state_q == ADP_RD) begin
            rd_beat_we = 1'b1;
          end else begin
            burst_d.wdata = buf_beat[1];
          end
          if (k_q == LAST_BEAT) begin
            state_d       = ADP_DONE;
            burst_d.read  = 1'b0;
            burst_d.write = 1'b0;
            line_resp_d   = 1'b1;
          end
        end
`ifdef ADAPTOR_TIMEOUT_EN
        else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
          if (idle_cnt_d == TIMEOUT_CYCLES[7:0]) begin
            state_d       = ADP_DONE;
            burst_d.read  = 1'b0;
            burst_d.write = 1'b0;
            line_resp_d   = 1'b1;
            line_err_d    = 1'b1;
          end
        end
`endif
      end
      ADP_DONE: state_d = ADP_IDLE;
      default:  state_d = ADP_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ADP_IDLE;
      k_q         <= '0;
      burst_q     <= '0;
      line_resp_q <= 1'b0;
`ifdef ADAPTOR_TIMEOUT_EN
      idle_cnt_q  <= '0;
      line_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      burst_q     <= burst_d;
      line_resp_q <= line_resp_d;
`ifdef ADAPTOR_TIMEOUT_EN
      idle_cnt_q  <= idle_cnt_d;
      line_err_q  <= line_err_d;
`endif
    end
  end

  assign line_rdata  = buf_line[0];
  assign line_resp   = line_resp_q;
  assign burst_read  = burst_q.read;
  assign burst_write = burst_q.write;
  assign burst_addr  = burst_q.addr;
  assign burst_wdata = burst_q.wdata;
`ifdef ADAPTOR_TIMEOUT_EN
  assign line_err    = line_err_q;
`else
  assign line_err    = 1'b0;
`endif

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed self-checking bench for cacheline_burst_adaptor; the no-response
// case exercises the watchdog when ADAPTOR_TIMEOUT_EN is defined (limit 16).
module tb_cacheline_burst_adaptor;

  logic         clk = 1'b0;
  logic         rst;
  logic         line_read, line_write;
  logic [31:0]  line_addr;
  logic [255:0] line_wdata, line_rdata;
  logic         line_resp, line_err;
  logic         burst_read, burst_write;
  logic [31:0]  burst_addr;
  logic [63:0]  burst_wdata, burst_rdata;
  logic         burst_resp;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  cacheline_burst_adaptor #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .line_read   (line_read),
    .line_write  (line_write),
    .line_addr   (line_addr),
    .line_wdata  (line_wdata),
    .line_rdata  (line_rdata),
    .line_resp   (line_resp),
    .line_err    (line_err),
    .burst_read  (burst_read),
    .burst_write (burst_write),
    .burst_addr  (burst_addr),
    .burst_wdata (burst_wdata),
    .burst_rdata (burst_rdata),
    .burst_resp  (burst_resp)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller raises the request; the task serves the beats and retires it.
  task automatic serve_read(input string tag, input logic [255:0] line, input logic [31:0] exp_addr,
                            input int gap_beat, input int gap_len, input int exp_lat);
    int lat;
    lat = 0;
    step(); lat++;
    chk({tag, "_rd_hi"}, burst_read, 1'b1);
    chk({tag, "_addr"}, burst_addr, exp_addr);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_no_wr"}, burst_write, 1'b0);
      burst_resp  = 1'b1;
      burst_rdata = line[64*i +: 64];
      step(); lat++;
      burst_resp  = 1'b0;
      burst_rdata = '0;
      if (i == gap_beat) begin
        for (int g = 0; g < gap_len; g++) begin
          chk({tag, "_gap_noresp"}, line_resp, 1'b0);
          step(); lat++;
        end
      end
    end
    line_read  = 1'b0;
    line_write = 1'b0;
    chk({tag, "_resp"}, line_resp, 1'b1);
    chk({tag, "_rdata"}, line_rdata, line);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_rd_lo"}, burst_read, 1'b0);
    step();
    chk({tag, "_resp_1cyc"}, line_resp, 1'b0);
    $display("read %s addr=%08h line=%064h", tag, exp_addr, line);
  endtask

  task automatic serve_write(input string tag, input logic [255:0] line, input logic [255:0] prev_rdata);
    step();
    chk({tag, "_wr_hi"}, burst_write, 1'b1);
    chk({tag, "_no_rd"}, burst_read, 1'b0);
    chk({tag, "_beat0"}, burst_wdata, line[63:0]);
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        step();
        chk({tag, "_hold"}, burst_wdata, line[128 +: 64]);
        chk({tag, "_hold_wr"}, burst_write, 1'b1);
      end
      burst_resp = 1'b1;
      step();
      burst_resp = 1'b0;
      if (i < 3) chk({tag, "_beat"}, burst_wdata, line[64*(i+1) +: 64]);
    end
    line_write = 1'b0;
    chk({tag, "_resp"}, line_resp, 1'b1);
    chk({tag, "_wr_lo"}, burst_write, 1'b0);
    chk({tag, "_rdata_kept"}, line_rdata, prev_rdata);
    step();
    chk({tag, "_resp_1cyc"}, line_resp, 1'b0);
    $display("write %s line=%064h", tag, line);
  endtask

  localparam logic [255:0] L1 = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
  localparam logic [255:0] L2 = {{8{8'hA3}}, {8{8'hA2}}, {8{8'hA1}}, {8{8'hA0}}};
  localparam logic [255:0] L3 = {64'h0102030405060708, 64'h1112131415161718,
                                 64'h2122232425262728, 64'h3132333435363738};
  localparam logic [255:0] L4 = {{8{8'h88}}, {8{8'h77}}, {8{8'h66}}, {8{8'h55}}};
  localparam logic [255:0] L5 = {{8{8'hC4}}, {8{8'hC3}}, {8{8'hC2}}, {8{8'hC1}}};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic seen;
    rst = 1'b1; line_read = 1'b0; line_write = 1'b0; line_addr = '0; line_wdata = '0;
    burst_rdata = '0; burst_resp = 1'b0;
    repeat (3) step();
    chk("rst_rdata", line_rdata, 256'h0);
    chk("rst_resp", line_resp, 1'b0);
    chk("rst_err", line_err, 1'b0);
    chk("rst_bread", burst_read, 1'b0);
    chk("rst_bwrite", burst_write, 1'b0);
    chk("rst_baddr", burst_addr, 32'h0);
    chk("rst_bwdata", burst_wdata, 64'h0);
    $display("reset done");
    rst = 1'b0;
    step();

    // Stray beat while idle must be ignored.
    burst_resp = 1'b1; burst_rdata = 64'hDEADBEEFDEADBEEF;
    step();
    burst_resp = 1'b0; burst_rdata = '0;
    step();
    chk("idle_resp_ign_rdata", line_rdata, 256'h0);
    chk("idle_resp_ign_resp", line_resp, 1'b0);
    chk("idle_resp_ign_bread", burst_read, 1'b0);
    $display("idle burst_resp ignored");

    line_read = 1'b1; line_addr = 32'h0000_1234;
    serve_read("rd_basic", L1, 32'h0000_1220, -1, 0, 5);

    line_write = 1'b1; line_addr = 32'h0000_ABCD; line_wdata = L2;
    serve_write("wr_basic", L2, L1);

    line_read = 1'b1; line_addr = 32'h2000_001F;
    serve_read("rd_gap", L3, 32'h2000_0000, 1, 3, 8);

    line_read = 1'b1; line_write = 1'b1; line_addr = 32'h3000_0040; line_wdata = L2;
    serve_read("rd_wins", L4, 32'h3000_0040, -1, 0, 5);

    // Reset after two beats of a read abandons it silently.
    line_read = 1'b1; line_addr = 32'h0000_0040;
    step();
    burst_resp = 1'b1; burst_rdata = {8{8'hAA}};
    step();
    burst_rdata = {8{8'hBB}};
    step();
    burst_resp = 1'b0; burst_rdata = '0;
    rst = 1'b1; line_read = 1'b0;
    step();
    chk("midrst_bread", burst_read, 1'b0);
    chk("midrst_resp", line_resp, 1'b0);
    chk("midrst_rdata", line_rdata, 256'h0);
    chk("midrst_baddr", burst_addr, 32'h0);
    chk("midrst_bwdata", burst_wdata, 64'h0);
    $display("mid-read reset applied");
    rst = 1'b0;
    step();
    chk("midrst_noresp", line_resp, 1'b0);
    line_read = 1'b1; line_addr = 32'h0000_0080;
    serve_read("rd_after_rst", L5, 32'h0000_0080, -1, 0, 5);

    // Memory never answers.
    seen = 1'b0;
    line_read = 1'b1; line_addr = 32'h0000_0100;
`ifdef ADAPTOR_TIMEOUT_EN
    for (int n = 1; n <= 16; n++) begin
      step();
      if (line_resp) seen = 1'b1;
    end
    chk("to_no_early_resp", seen, 1'b0);
    chk("to_bread_before", burst_read, 1'b1);
    step();
    line_read = 1'b0;
    chk("to_resp", line_resp, 1'b1);
    chk("to_err", line_err, 1'b1);
    chk("to_bread_drop", burst_read, 1'b0);
    chk("to_rdata_kept", line_rdata, L5);
    step();
    chk("to_resp_1cyc", line_resp, 1'b0);
    chk("to_err_clr", line_err, 1'b0);
    $display("timeout abort observed");
`else
    for (int n = 0; n < 1000; n++) begin
      step();
      if (line_resp) seen = 1'b1;
    end
    chk("nores_no_resp", seen, 1'b0);
    chk("nores_bread", burst_read, 1'b1);
    chk("nores_err", line_err, 1'b0);
    $display("no response for 1000 cycles, still waiting");
    rst = 1'b1; line_read = 1'b0;
    step();
    rst = 1'b0;
    step();
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
